// File: rtl/seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_pkg : shared types and constants for the 11011 marker link   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GUARD = 3'd1,
        ST_MARK  = 3'd2,
        ST_DATA  = 3'd3,
        ST_STUFF = 3'd4
    } state_t;

    localparam logic [4:0] MARKER    = 5'b11011;
    localparam int         MARK_LEN  = 5;
    // Seeing this tail means one more 1 would complete a marker.
    localparam logic [3:0] STUFF_PAT = 4'b1101;

endpackage
`default_nettype wire

// File: rtl/seq_stuff_mon.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_stuff_mon : 4-bit line history and stuff request flag        |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module seq_stuff_mon
    import seq_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic bit_i,
    output logic stuff_req_o
);

    logic [3:0] hist_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[2:0], bit_i};
        end
    end

    assign stuff_req_o = (hist_q == STUFF_PAT);

endmodule
`default_nettype wire

// File: rtl/seq_framer_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_framer_tx : guard + 11011 marker + bit-stuffed payload TX    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module seq_framer_tx
    import seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int GUARD  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx_o,
    output logic              frame_o,
    output logic              busy_o
);

    localparam int CNT_MAX = (GUARD > MARK_LEN) ? GUARD : MARK_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int PAY_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    if (GUARD < 2) begin : g_guard_chk
        $error("seq_framer_tx: GUARD must be at least 2");
    end
    if (DATA_W < 1) begin : g_width_chk
        $error("seq_framer_tx: DATA_W must be at least 1");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PAY_W-1:0]   pay_q, pay_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               frame_q, frame_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               stuff_req;
    logic [2:0]         mark_idx;

    // The monitor tracks the bit about to be driven, so its history
    // always includes the bit on the line in the current cycle.
    seq_stuff_mon u_stuff_mon (
        .clk         (clk),
        .reset_n     (reset_n),
        .bit_i       (tx_d),
        .stuff_req_o (stuff_req)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pay_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pay_q   <= pay_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pay_d   = pay_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_i && ready_q) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                    pay_d   = '0;
                    shift_d = data_i;
                end
            end
            ST_GUARD: begin
                if (cnt_q == CNT_W'(GUARD - 1)) begin
                    state_d = ST_MARK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_MARK: begin
                if (cnt_q == CNT_W'(MARK_LEN - 1)) begin
                    state_d = stuff_req ? ST_STUFF : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                shift_d = shift_q << 1;
                // A stuff pending after the last bit is dropped; the next
                // frame's guard zeros break the pattern instead.
                if (pay_q == PAY_W'(DATA_W - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    pay_d   = pay_q + PAY_W'(1);
                    state_d = stuff_req ? ST_STUFF : ST_DATA;
                end
            end
            ST_STUFF: begin
                state_d = ST_DATA;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mark_idx = 3'(MARK_LEN - 1) - cnt_d[2:0];

    always_comb begin
        tx_d = 1'b0;
        case (state_d)
            ST_MARK: tx_d = MARKER[mark_idx];
            ST_DATA: tx_d = shift_d[DATA_W-1];
            default: tx_d = 1'b0;
        endcase
        frame_d = (state_d == ST_MARK) || (state_d == ST_DATA) || (state_d == ST_STUFF);
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    assign tx_o    = tx_q;
    assign frame_o = frame_q;
    assign busy_o  = busy_q;
    assign ready_o = ready_q;

endmodule
`default_nettype wire
